// File: rtl/gpio_apb_master_if.sv
// APB bus bundle between the gpio_apb_master and the GPIO slave.
// The master drives the control/address/write-data lines; the slave returns data and status.
interface gpio_apb_master_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
);
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/gpio_apb_master.sv
// Two-port round-robin arbiter plus APB master sequencing one transfer at a time into the GPIO slave.
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
module gpio_apb_master #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    presetn,
   input  logic [1:0]              req_valid,
   input  logic [1:0]              req_write,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [2*DATA_WIDTH-1:0] req_wdata,
   output logic [1:0]              rsp_done,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,
   output logic                    rsp_timeout,
   gpio_apb_master_if.master       apb
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("gpio_apb_master: TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t                state_q, state_d;
   logic                  psel_q, psel_d;
   logic                  penable_q, penable_d;
   logic                  pwrite_q, pwrite_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic [1:0]            rsp_done_q, rsp_done_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;
   logic                  prio_q, prio_d;
   logic                  winner_q, winner_d;

   logic [1:0]            eligible;
   logic                  gnt;

`ifdef APB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
   logic                  rsp_timeout_q, rsp_timeout_d;
   logic                  expire;
   assign expire = (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));
`endif

   // A requester in its own done cycle is masked so the other one can win that edge.
   assign eligible = req_valid & ~rsp_done_q;
   assign gnt      = (eligible == 2'b11) ? prio_q : eligible[1];

   always_comb begin
      state_d     = state_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_done_d  = 2'b00;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
      prio_d      = prio_q;
      winner_d    = winner_q;
`ifdef APB_TIMEOUT_EN
      wait_cnt_d    = wait_cnt_q;
      rsp_timeout_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (|eligible) begin
               winner_d = gnt;
               pwrite_d = gnt ? req_write[1] : req_write[0];
               paddr_d  = gnt ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
               pwdata_d = gnt ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
               psel_d   = 1'b1;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
         end
         ACCESS: begin
            if (apb.pready) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_done_d  = winner_q ? 2'b10 : 2'b01;
               rsp_err_d   = apb.pslverr;
               rsp_rdata_d = pwrite_q ? '0 : apb.prdata;
               prio_d      = ~winner_q;
               state_d     = IDLE;
            end
`ifdef APB_TIMEOUT_EN
            else if (expire) begin
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_done_d    = winner_q ? 2'b10 : 2'b01;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               prio_d        = ~winner_q;
               state_d       = IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
`endif
         end
         default: begin
            state_d   = IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge presetn) begin
      if (!presetn) begin
         state_q     <= IDLE;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_done_q  <= 2'b00;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         prio_q      <= 1'b0;
         winner_q    <= 1'b0;
`ifdef APB_TIMEOUT_EN
         wait_cnt_q    <= '0;
         rsp_timeout_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_done_q  <= rsp_done_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         prio_q      <= prio_d;
         winner_q    <= winner_d;
`ifdef APB_TIMEOUT_EN
         wait_cnt_q    <= wait_cnt_d;
         rsp_timeout_q <= rsp_timeout_d;
`endif
      end
   end

   assign apb.psel    = psel_q;
   assign apb.penable = penable_q;
   assign apb.pwrite  = pwrite_q;
   assign apb.paddr   = paddr_q;
   assign apb.pwdata  = pwdata_q;
   assign rsp_done    = rsp_done_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
`ifdef APB_TIMEOUT_EN
   assign rsp_timeout = rsp_timeout_q;
`else
   assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_apb_master.sv
// Directed bench for gpio_apb_master: latency, arbitration, error, reset and timeout scenarios.
// Build with APB_TIMEOUT_EN defined to exercise the timeout abort path.
module tb_gpio_apb_master;
   localparam int DW = 32;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          presetn = 1'b0;
   logic [1:0]    req_valid = '0;
   logic [1:0]    req_write = '0;
   logic [2*AW-1:0] req_addr = '0;
   logic [2*DW-1:0] req_wdata = '0;
   logic [1:0]    rsp_done;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          rsp_timeout;

   int            n_checks = 0;
   int            n_errors = 0;

   // Slave model: pready rises after 'ready_delay' ACCESS cycles.
   int            ready_delay = 0;
   int            acc_cnt = 0;
   logic          ready_r = 1'b0;
   logic          force_ready = 1'b0;
   logic [DW-1:0] rd_val = '0;
   logic          slverr_val = 1'b0;

   gpio_apb_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) apb_if ();

   assign apb_if.prdata  = rd_val;
   assign apb_if.pready  = ready_r | force_ready;
   assign apb_if.pslverr = slverr_val;

   gpio_apb_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(4)) dut (
      .clk        (clk),
      .presetn    (presetn),
      .req_valid  (req_valid),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_done   (rsp_done),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .rsp_timeout(rsp_timeout),
      .apb        (apb_if)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (apb_if.psel && apb_if.penable) begin
         ready_r = (acc_cnt == ready_delay);
         acc_cnt = acc_cnt + 1;
      end else begin
         ready_r = 1'b0;
         acc_cnt = 0;
      end
   end

   // Waits (bounded) for a done pulse, counting negedges since the call and psel/penable cycles.
   task automatic wait_done(input logic [1:0] drop_mask, output int k, output logic [1:0] done,
                            output logic [DW-1:0] rdata, output logic err, output logic tmo,
                            output int psel_n, output int pen_n);
      k = 0; done = '0; rdata = '0; err = 0; tmo = 0; psel_n = 0; pen_n = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         k++;
         if (apb_if.psel) psel_n++;
         if (apb_if.penable) pen_n++;
         if (rsp_done != 2'b00) begin
            done = rsp_done; rdata = rsp_rdata; err = rsp_err; tmo = rsp_timeout;
            req_valid = req_valid & ~(rsp_done & drop_mask);
            break;
         end
      end
   endtask

   task automatic test_reset;
      presetn = 1'b0;
      #3;
      n_checks++;
      if ({apb_if.psel, apb_if.penable, apb_if.pwrite, rsp_err, rsp_timeout, rsp_done} !== 7'b0) begin
         n_errors++; $display("FAIL reset_ctrl: got %b required 0000000",
            {apb_if.psel, apb_if.penable, apb_if.pwrite, rsp_err, rsp_timeout, rsp_done});
      end
      n_checks++;
      if ({apb_if.paddr, apb_if.pwdata, rsp_rdata} !== '0) begin
         n_errors++; $display("FAIL reset_data: paddr %h pwdata %h rdata %h required 0",
            apb_if.paddr, apb_if.pwdata, rsp_rdata);
      end
      repeat (2) @(negedge clk);
      presetn = 1'b1;
      @(negedge clk);
      $display("reset: outputs cleared");
   endtask

   task automatic test_write;
      int k, ps, pe; logic [1:0] d; logic [DW-1:0] rd; logic e, t;
      ready_delay = 0;
      req_write = 2'b01; req_addr[AW-1:0] = 8'h04; req_wdata[DW-1:0] = 32'hDEADBEEF;
      req_valid = 2'b01;
      @(negedge clk);
      n_checks++;
      if ({apb_if.psel, apb_if.penable, apb_if.pwrite, apb_if.paddr, apb_if.pwdata} !== {3'b101, 8'h04, 32'hDEADBEEF}) begin
         n_errors++; $display("FAIL write_setup: psel %b penable %b pwrite %b paddr %h pwdata %h required 1 0 1 04 deadbeef",
            apb_if.psel, apb_if.penable, apb_if.pwrite, apb_if.paddr, apb_if.pwdata);
      end
      wait_done(2'b11, k, d, rd, e, t, ps, pe);
      k = k + 1; ps = ps + 1;
      n_checks++;
      if (k !== 3 || d !== 2'b01) begin
         n_errors++; $display("FAIL write_latency: got %0d cycles done %b required 3 cycles done 01", k, d);
      end
      n_checks++;
      if (ps !== 2 || pe !== 1) begin
         n_errors++; $display("FAIL write_phases: psel %0d penable %0d cycles required 2 and 1", ps, pe);
      end
      n_checks++;
      if (e !== 1'b0 || rd !== '0 || t !== 1'b0) begin
         n_errors++; $display("FAIL write_rsp: err %b tmo %b rdata %h required 0 0 0", e, t, rd);
      end
      $display("write req0 addr 04 data deadbeef: done %b after %0d cycles", d, k);
   endtask

   task automatic test_read_wait;
      int k, ps, pe; logic [1:0] d; logic [DW-1:0] rd; logic e, t;
      ready_delay = 2; rd_val = 32'h12345678;
      req_write = 2'b00; req_addr[2*AW-1:AW] = 8'h08;
      req_valid = 2'b10;
      wait_done(2'b11, k, d, rd, e, t, ps, pe);
      n_checks++;
      if (k !== 5 || d !== 2'b10) begin
         n_errors++; $display("FAIL read_latency: got %0d cycles done %b required 5 cycles done 10", k, d);
      end
      n_checks++;
      if (rd !== 32'h12345678 || e !== 1'b0) begin
         n_errors++; $display("FAIL read_data: rdata %h err %b required 12345678 0", rd, e);
      end
      @(negedge clk);
      n_checks++;
      if (rsp_rdata !== '0 || rsp_done !== 2'b00) begin
         n_errors++; $display("FAIL read_pulse: rdata %h done %b one cycle later required 0 00", rsp_rdata, rsp_done);
      end
      $display("read req1 addr 08 wait 2: rdata %h after %0d cycles", rd, k);
   endtask

   task automatic test_back_to_back;
      int k, ps, pe; logic [1:0] d; logic [DW-1:0] rd; logic e, t;
      logic [1:0] exp_done [4];
      exp_done[0] = 2'b01; exp_done[1] = 2'b10; exp_done[2] = 2'b01; exp_done[3] = 2'b10;
      ready_delay = 0; rd_val = 32'h0000A5A5;
      req_write = 2'b01;
      req_addr  = {8'h20, 8'h10};
      req_wdata = {32'h0, 32'h11112222};
      req_valid = 2'b11;
      for (int n = 0; n < 4; n++) begin
         wait_done(2'b00, k, d, rd, e, t, ps, pe);
         if (n == 3) req_valid = 2'b00;
         n_checks++;
         if (d !== exp_done[n] || k !== 3) begin
            n_errors++; $display("FAIL b2b_grant%0d: done %b after %0d cycles required %b after 3", n, d, k, exp_done[n]);
         end
         n_checks++;
         if (rd !== (d[1] ? 32'h0000A5A5 : 32'h0)) begin
            n_errors++; $display("FAIL b2b_rdata%0d: got %h required %h", n, rd, d[1] ? 32'h0000A5A5 : 32'h0);
         end
         $display("back-to-back transfer %0d: done %b rdata %h", n, d, rd);
      end
      @(negedge clk);
   endtask

   task automatic test_slverr;
      int k, ps, pe; logic [1:0] d; logic [DW-1:0] rd; logic e, t;
      ready_delay = 1; rd_val = 32'hCAFEF00D; slverr_val = 1'b1;
      req_write = 2'b00; req_addr[AW-1:0] = 8'h0C;
      req_valid = 2'b01;
      wait_done(2'b11, k, d, rd, e, t, ps, pe);
      slverr_val = 1'b0;
      n_checks++;
      if (k !== 4 || d !== 2'b01 || e !== 1'b1 || rd !== 32'hCAFEF00D) begin
         n_errors++; $display("FAIL slverr: cycles %0d done %b err %b rdata %h required 4 01 1 cafef00d", k, d, e, rd);
      end
      $display("read with pslverr: done %b err %b rdata %h", d, e, rd);
   endtask

   task automatic test_reset_mid;
      int k, ps, pe; logic [1:0] d; logic [DW-1:0] rd; logic e, t;
      int seen_done;
      ready_delay = 1000;
      req_write = 2'b00; req_addr = {8'h30, 8'h18};
      req_valid = 2'b01;
      repeat (3) @(negedge clk);
      n_checks++;
      if (apb_if.psel !== 1'b1 || apb_if.penable !== 1'b1) begin
         n_errors++; $display("FAIL rst_mid_access: psel %b penable %b required 1 1", apb_if.psel, apb_if.penable);
      end
      #2 presetn = 1'b0;
      #1;
      n_checks++;
      if (apb_if.psel !== 1'b0 || apb_if.penable !== 1'b0) begin
         n_errors++; $display("FAIL rst_mid_clear: psel %b penable %b required 0 0", apb_if.psel, apb_if.penable);
      end
      req_valid = 2'b00;
      seen_done = 0;
      repeat (2) begin
         @(negedge clk);
         if (rsp_done !== 2'b00) seen_done++;
      end
      presetn = 1'b1;
      ready_delay = 0;
      @(negedge clk);
      if (rsp_done !== 2'b00) seen_done++;
      n_checks++;
      if (seen_done !== 0) begin
         n_errors++; $display("FAIL rst_mid_nodone: %0d done cycles required 0", seen_done);
      end
      req_valid = 2'b11;
      wait_done(2'b11, k, d, rd, e, t, ps, pe);
      n_checks++;
      if (d !== 2'b01) begin
         n_errors++; $display("FAIL rst_first_grant: done %b required 01", d);
      end
      wait_done(2'b11, k, d, rd, e, t, ps, pe);
      n_checks++;
      if (d !== 2'b10) begin
         n_errors++; $display("FAIL rst_second_grant: done %b required 10", d);
      end
      @(negedge clk);
      $display("reset during ACCESS: no done, first grant after reset to req0");
   endtask

   task automatic test_timeout;
      int k, ps, pe; logic [1:0] d; logic [DW-1:0] rd; logic e, t;
      ready_delay = 1000; rd_val = 32'h55AA55AA;
      req_write = 2'b00; req_addr[2*AW-1:AW] = 8'h40;
      req_valid = 2'b10;
`ifdef APB_TIMEOUT_EN
      wait_done(2'b11, k, d, rd, e, t, ps, pe);
      n_checks++;
      if (k !== 6 || d !== 2'b10 || e !== 1'b1 || t !== 1'b1 || rd !== '0) begin
         n_errors++; $display("FAIL timeout_abort: cycles %0d done %b err %b tmo %b rdata %h required 6 10 1 1 0", k, d, e, t, rd);
      end
      $display("timeout abort: done %b err %b tmo %b after %0d cycles", d, e, t, k);
`else
      begin
         int held;
         held = 0;
         repeat (2) @(negedge clk);
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (apb_if.psel && apb_if.penable && rsp_done == 2'b00) held++;
         end
         n_checks++;
         if (held !== 100) begin
            n_errors++; $display("FAIL access_hold: held %0d cycles required 100", held);
         end
         force_ready = 1'b1;
         wait_done(2'b11, k, d, rd, e, t, ps, pe);
         force_ready = 1'b0;
         n_checks++;
         if (k !== 1 || d !== 2'b10 || t !== 1'b0 || rd !== 32'h55AA55AA) begin
            n_errors++; $display("FAIL access_release: cycles %0d done %b tmo %b rdata %h required 1 10 0 55aa55aa", k, d, t, rd);
         end
         $display("no timeout: ACCESS held %0d cycles, then done %b", held, d);
      end
`endif
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_wait();
      test_back_to_back();
      test_slverr();
      test_reset_mid();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/gpio_apb_master.md
# gpio_apb_master

APB master and two-port round-robin arbiter that sequences transfers into the GPIO APB slave. It sits between two internal requesters (e.g. CPU-side bus bridge and DMA/test port) and the GPIO peripheral. It runs the APB SETUP/ACCESS protocol, waits on `pready`, and returns read data or error to the winning requester. One transfer is in flight at a time.

## Interface
Parameters:
- `DATA_WIDTH`, 32, APB data width; matches the GPIO slave.
- `ADDR_WIDTH`, 8, APB address width.
- `TIMEOUT_CYCLES`, 16, ACCESS-phase wait limit (used only with `APB_TIMEOUT_EN`); must be ≥1.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `presetn`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  2  per-requester request; bit i = requester i.
- `req_write`  in  2  per-requester direction, 1 = write.
- `req_addr`  in  2*ADDR_WIDTH  requester i at `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `req_wdata`  in  2*DATA_WIDTH  requester i at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `rsp_done`  out  2  one-cycle completion pulse to requester i.
- `rsp_rdata`  out  DATA_WIDTH  read data, valid while `rsp_done` is nonzero.
- `rsp_err`  out  1  error flag, valid while `rsp_done` is nonzero.
- `rsp_timeout`  out  1  timeout flag, valid while `rsp_done` is nonzero.
- `psel`, `penable`, `pwrite`  out  1 each  APB control.
- `paddr`  out  ADDR_WIDTH  APB address.
- `pwdata`  out  DATA_WIDTH  APB write data.
- `prdata`  in  DATA_WIDTH  APB read data.
- `pready`  in  1  slave ready.
- `pslverr`  in  1  slave error.

## Operation
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE: form the eligible mask `req_valid & ~rsp_done`. If it is nonzero, grant using a round-robin pointer.
  - The pointer favours the requester not granted last.
  - On the grant, capture `req_write`/`req_addr`/`req_wdata` of the winner into `pwrite`/`paddr`/`pwdata`, set `psel`=1, go to SETUP.
- SETUP: `penable`←1, go to ACCESS. Always exactly one cycle.
- ACCESS: hold all APB outputs stable. On `pready`=1:
  - `psel`,`penable`←0.
  - `rsp_done[winner]`←1.
  - `rsp_err`←`pslverr`.
  - `rsp_rdata`←`prdata` for reads, 0 for writes.
  - Update the pointer; go to IDLE.
- `rsp_done`, `rsp_err`, `rsp_timeout` are one-cycle pulses. `rsp_rdata` returns to 0 the cycle after.
- Requesters hold request fields until `rsp_done[i]`. Changes after the grant are ignored (fields are captured). Dropping `req_valid` mid-transfer does not cancel it; done still pulses.
- Requester i's `req_valid` is masked in its own done cycle, so it must deassert there. The other requester may be granted on that same edge.
- Both valid in IDLE: the pointer decides. After reset, requester 0 wins.
- `pwrite`/`paddr`/`pwdata` hold their last values in IDLE.

## Timing
- Reset values: state IDLE; all outputs 0; pointer favours requester 0.
- Reset is asserted asynchronously. It clears APB outputs immediately, including mid-transfer, with no `rsp_done` pulse.
- Latency: `req_valid` sampled at edge E0 → `psel`=1 after E0 → `penable`=1 after E1. `pready` sampled high at E2 → `rsp_done` high in the cycle after E2. Minimum 3 cycles; each `pready`=0 wait adds one.
- Back-to-back throughput: one transfer per 3 cycles minimum. IDLE always lasts at least one cycle.
- `pready` and `pslverr` are ignored outside ACCESS.

## Configuration
- Macro: `APB_TIMEOUT_EN`.
- Defined: an ACCESS-cycle counter is cleared on entry to ACCESS and counts each ACCESS cycle with `pready`=0.
  - When it reaches `TIMEOUT_CYCLES`, the transfer aborts: `psel`/`penable`←0, `rsp_done[winner]`=1, `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0, go to IDLE.
  - `pready` arriving on the same edge as the limit wins: normal completion, `rsp_timeout`=0.
- Not defined: no counter; ACCESS waits indefinitely; `rsp_timeout` tied to 0.

## Test plan
- Write from req0 (addr 0x04, data 0xDEADBEEF), `pready`=1 immediately → `psel` for 2 cycles, `penable` for 1; `pwdata`=0xDEADBEEF; `rsp_done`=2'b01 3 cycles after request; `rsp_err`=0.
- Read from req1, `prdata`=0x12345678, `pready` delayed 2 cycles → `rsp_done`=2'b10 5 cycles after request; `rsp_rdata`=0x12345678 for exactly one cycle.
- Both requesters valid continuously for 4 transfers → grants alternate 0,1,0,1; each `rsp_done` pulse is one cycle.
- Read with `pslverr`=1 at `pready` → `rsp_err`=1 with `rsp_done`; `rsp_rdata` = `prdata`.
- `presetn` low during ACCESS → `psel`=`penable`=0 immediately; no `rsp_done`; after release, the first grant goes to req0.
- With `APB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, `pready` held 0 → abort after 4 ACCESS cycles with `rsp_err`=`rsp_timeout`=1; without the macro, ACCESS holds for 100 cycles.
